prog_sequencer: RTL and testbench

- Parametrised run controller and program counter for the core: owns the req/done handshake, program selection, PC update (relative/absolute jump, stall), end-of-program detection and a cycle watchdog.
- Generalises the fixed "done when PC == 128" scheme.
- Program memory is split into NPROG equal regions. Each region holds one program, selected per request.
- Sits between the top level and instr_ROM; Control drives the jump, halt and stall inputs.

---
 rtl/prog_sequencer.sv | 149 ++++++++++++++
 tb/tb_prog_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Run controller and program counter: req/done handshake, program region
// selection, PC update (relative/absolute jump, stall), end-of-program
// detection and a RUN-cycle watchdog.
module prog_sequencer #(
   parameter int unsigned D          = 12,
   parameter int unsigned NPROG      = 4,
   parameter int unsigned CW         = 16,
   parameter int unsigned MAX_CYCLES = 4096
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      req,
   input  logic [$clog2((NPROG > 1) ? NPROG : 2)-1:0] prog_sel,
   input  logic                                      reljump_en,
   input  logic                                      absjump_en,
   input  logic [D-1:0]                              target,
   input  logic                                      halt_instr,
   input  logic                                      stall,
   output logic [D-1:0]                              prog_ctr,
   output logic                                      run,
   output logic                                      done,
   output logic                                      timeout,
   output logic [CW-1:0]                             cycle_cnt
);

   localparam int unsigned SW = $clog2((NPROG > 1) ? NPROG : 2);
   // Region size; the tail addresses beyond NPROG*R belong to no program.
   localparam int unsigned R  = (2 ** D) / NPROG;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StRun,
      StDone
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [D-1:0]  pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   logic [D-1:0]  region_base;
   logic [D-1:0]  region_last;
   logic          wd_hit;
   logic          finish;

   // Region bounds of the latched program. The true product never exceeds
   // 2**D-1, so computing in D bits is exact.
   assign region_base = D'(sel_q) * D'(R);
   assign region_last = region_base + D'(R - 1);

   // Watchdog fires on the RUN cycle whose count reaches MAX_CYCLES-1.
   assign wd_hit = (MAX_CYCLES != 0) && (32'(cnt_q) == MAX_CYCLES - 1);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         sel_q     <= '0;
         pc_q      <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic: handshake, PC update priority and finish detection.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      finish    = 1'b0;

      unique case (state_q)
         StIdle: begin
            timeout_d = 1'b0;
            if (req) begin
               // Out-of-range selections fall back to program 0.
               if (32'(prog_sel) >= NPROG) begin
                  sel_d = '0;
               end else begin
                  sel_d = SW'(prog_sel);
               end
               state_d = StLoad;
            end
         end

         StLoad: begin
            pc_d    = region_base;
            cnt_d   = '0;
            state_d = StRun;
         end

         StRun: begin
            if (wd_hit) begin
               finish    = 1'b1;
               timeout_d = 1'b1;
            end else if (stall) begin
               pc_d = pc_q;
            end else if (halt_instr) begin
               finish = 1'b1;
            end else if (absjump_en) begin
               pc_d = target;
            end else if (reljump_en) begin
               pc_d = pc_q + target;
            end else if (pc_q == region_last) begin
               finish = 1'b1;
            end else begin
               pc_d = pc_q + D'(1);
            end

            // The finishing cycle is not counted, so a full region of N
            // instructions reports N-1 and the watchdog stops at MAX_CYCLES-1.
            if (finish) begin
               state_d = StDone;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         StDone: begin
            if (!req) begin
               state_d   = StIdle;
               timeout_d = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are plain decodes of registered state.
   assign prog_ctr  = pc_q;
   assign run       = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign timeout   = timeout_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: two instances (4 regions without
// watchdog, 3 regions with an 8-cycle watchdog) driven by shared stimulus.
module tb_prog_sequencer;

   typedef struct packed {
      logic [11:0] pc;
      logic        to;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [1:0]  prog_sel;
   logic        reljump_en;
   logic        absjump_en;
   logic [11:0] target;
   logic        halt_instr;
   logic        stall;

   logic [11:0] a_pc, b_pc;
   logic        a_run, b_run, a_done, b_done, a_to, b_to;
   logic [15:0] a_cnt, b_cnt;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   prog_sequencer #(.D(12), .NPROG(4), .CW(16), .MAX_CYCLES(0)) dut_a (
      .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
      .reljump_en(reljump_en), .absjump_en(absjump_en), .target(target),
      .halt_instr(halt_instr), .stall(stall), .prog_ctr(a_pc), .run(a_run),
      .done(a_done), .timeout(a_to), .cycle_cnt(a_cnt)
   );

   prog_sequencer #(.D(12), .NPROG(3), .CW(16), .MAX_CYCLES(8)) dut_b (
      .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel),
      .reljump_en(reljump_en), .absjump_en(absjump_en), .target(target),
      .halt_instr(halt_instr), .stall(stall), .prog_ctr(b_pc), .run(b_run),
      .done(b_done), .timeout(b_to), .cycle_cnt(b_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 1'b0; prog_sel = 2'd0; reljump_en = 1'b0;
      absjump_en = 1'b0; target = 12'd0; halt_instr = 1'b0; stall = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (a_pc !== 12'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", a_pc); end
      n_cmp++; if ({a_run, a_done, a_to} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {a_run, a_done, a_to}); end
      n_cmp++; if (a_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
      n_cmp++; if ({b_pc, b_run, b_done, b_to, b_cnt} !== 31'd0) begin n_err++; $display("FAIL reset_b: got pc=%0d run=%b done=%b to=%b cnt=%0d want all 0", b_pc, b_run, b_done, b_to, b_cnt); end
   endtask

   task automatic test_normal();
      bit seen; bit inc_ok; logic [11:0] prev; exp_t e;
      do_reset();
      prog_sel = 2'd2; req = 1'b1;
      tick();
      n_cmp++; if ({a_run, a_done} !== 2'b00) begin n_err++; $display("FAIL load_flags: got run/done=%b want 00", {a_run, a_done}); end
      tick();
      n_cmp++; if (a_pc !== 12'd2048) begin n_err++; $display("FAIL normal_start_pc: got %0d want 2048", a_pc); end
      n_cmp++; if (a_run !== 1'b1 || a_cnt !== 16'd0) begin n_err++; $display("FAIL normal_start_run: got run=%b cnt=%0d want run=1 cnt=0", a_run, a_cnt); end
      req = 1'b0;  // ignored while running
      e.pc = 12'd3071; e.to = 1'b0; e.cnt = 16'd1023;
      sb.push_back(e);
      seen = 1'b0; inc_ok = 1'b1;
      for (int i = 0; i < 1100 && !seen; i++) begin
         prev = a_pc;
         tick();
         if (a_done === 1'b1) seen = 1'b1;
         else if (a_pc !== prev + 12'd1) inc_ok = 1'b0;
      end
      e = sb.pop_front();
      n_cmp++; if (!inc_ok) begin n_err++; $display("FAIL normal_increment: got non-unit step want +1 per cycle"); end
      n_cmp++;
      if (!seen) begin
         n_err++; $display("FAIL normal_done: got done=0 within 1100 cycles want done=1");
      end else begin
         n_cmp++; if (a_pc !== e.pc) begin n_err++; $display("FAIL normal_end_pc: got %0d want %0d", a_pc, e.pc); end
         n_cmp++; if (a_to !== e.to) begin n_err++; $display("FAIL normal_timeout: got %b want %b", a_to, e.to); end
         n_cmp++; if (a_cnt !== e.cnt) begin n_err++; $display("FAIL normal_cnt: got %0d want %0d", a_cnt, e.cnt); end
      end
      tick();
      n_cmp++; if ({a_done, a_run} !== 2'b00) begin n_err++; $display("FAIL normal_release: got done/run=%b want 00", {a_done, a_run}); end
   endtask

   task automatic test_jump();
      exp_t e;
      do_reset();
      prog_sel = 2'd0; req = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 10; i++) tick();
      n_cmp++; if (a_pc !== 12'd10) begin n_err++; $display("FAIL jump_pre_pc: got %0d want 10", a_pc); end
      reljump_en = 1'b1; target = 12'hFFC;
      tick();
      n_cmp++; if (a_pc !== 12'd6) begin n_err++; $display("FAIL reljump_back: got %0d want 6", a_pc); end
      absjump_en = 1'b1; target = 12'd300;
      tick();
      n_cmp++; if (a_pc !== 12'd300) begin n_err++; $display("FAIL absjump_priority: got %0d want 300", a_pc); end
      reljump_en = 1'b0; absjump_en = 1'b0;
      tick();
      n_cmp++; if (a_pc !== 12'd301) begin n_err++; $display("FAIL jump_resume: got %0d want 301", a_pc); end
      e.pc = 12'd301; e.to = 1'b0; e.cnt = 16'd13;
      sb.push_back(e);
      halt_instr = 1'b1;
      tick();
      halt_instr = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (a_done !== 1'b1 || a_pc !== e.pc || a_cnt !== e.cnt) begin n_err++; $display("FAIL jump_halt: got done=%b pc=%0d cnt=%0d want done=1 pc=%0d cnt=%0d", a_done, a_pc, a_cnt, e.pc, e.cnt); end
      req = 1'b0;
      tick();
   endtask

   task automatic test_stall_halt();
      exp_t e; bit held;
      do_reset();
      prog_sel = 2'd1; req = 1'b1;
      tick();
      tick();
      tick();
      n_cmp++; if (a_pc !== 12'd1025) begin n_err++; $display("FAIL stall_pre_pc: got %0d want 1025", a_pc); end
      stall = 1'b1; halt_instr = 1'b1;
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (a_pc !== 12'd1025 || a_done !== 1'b0) held = 1'b0;
      end
      n_cmp++; if (!held) begin n_err++; $display("FAIL stall_hold: got pc=%0d done=%b want pc=1025 done=0", a_pc, a_done); end
      e.pc = 12'd1025; e.to = 1'b0; e.cnt = 16'd4;
      sb.push_back(e);
      stall = 1'b0;
      tick();
      halt_instr = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (a_done !== 1'b1 || a_pc !== e.pc) begin n_err++; $display("FAIL stall_halt_done: got done=%b pc=%0d want done=1 pc=%0d", a_done, a_pc, e.pc); end
      n_cmp++; if (a_cnt !== e.cnt) begin n_err++; $display("FAIL stall_cnt: got %0d want %0d", a_cnt, e.cnt); end
      req = 1'b0;
      tick();
   endtask

   task automatic test_watchdog();
      exp_t e; int n; bit held;
      do_reset();
      prog_sel = 2'd1; req = 1'b1;
      tick();
      tick();
      n_cmp++; if (b_pc !== 12'd1365) begin n_err++; $display("FAIL wd_start_pc: got %0d want 1365", b_pc); end
      absjump_en = 1'b1; target = 12'd1365;
      e.pc = 12'd1365; e.to = 1'b1; e.cnt = 16'd7;
      sb.push_back(e);
      n = 0;
      while (b_done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      absjump_en = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (n != 8) begin n_err++; $display("FAIL wd_latency: got %0d run cycles want 8", n); end
      n_cmp++; if (b_done !== 1'b1 || b_to !== e.to) begin n_err++; $display("FAIL wd_flags: got done=%b timeout=%b want done=1 timeout=%b", b_done, b_to, e.to); end
      n_cmp++; if (b_pc !== e.pc || b_cnt !== e.cnt) begin n_err++; $display("FAIL wd_state: got pc=%0d cnt=%0d want pc=%0d cnt=%0d", b_pc, b_cnt, e.pc, e.cnt); end
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (b_done !== 1'b1 || b_to !== 1'b1) held = 1'b0;
      end
      n_cmp++; if (!held) begin n_err++; $display("FAIL wd_hold: got done=%b timeout=%b want 1 1", b_done, b_to); end
      req = 1'b0;
      tick();
      n_cmp++; if (b_done !== 1'b0 || b_to !== 1'b0) begin n_err++; $display("FAIL wd_release: got done=%b timeout=%b want 0 0", b_done, b_to); end
   endtask

   task automatic test_back_to_back();
      exp_t e; bit held;
      do_reset();
      prog_sel = 2'd3; req = 1'b1;
      tick();
      tick();
      n_cmp++; if (b_pc !== 12'd0 || b_run !== 1'b1) begin n_err++; $display("FAIL clamp_pc: got pc=%0d run=%b want pc=0 run=1", b_pc, b_run); end
      e.pc = 12'd0; e.to = 1'b0; e.cnt = 16'd0;
      sb.push_back(e);
      halt_instr = 1'b1;
      tick();
      halt_instr = 1'b0;
      e = sb.pop_front();
      n_cmp++; if (b_done !== 1'b1 || b_pc !== e.pc || b_cnt !== e.cnt) begin n_err++; $display("FAIL clamp_done: got done=%b pc=%0d cnt=%0d want done=1 pc=%0d cnt=%0d", b_done, b_pc, b_cnt, e.pc, e.cnt); end
      prog_sel = 2'd2;
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (b_done !== 1'b1 || b_run !== 1'b0 || b_pc !== 12'd0) held = 1'b0;
      end
      n_cmp++; if (!held) begin n_err++; $display("FAIL b2b_no_restart: got done=%b run=%b pc=%0d want 1 0 0", b_done, b_run, b_pc); end
      req = 1'b0;
      tick();
      req = 1'b1;
      tick();
      tick();
      n_cmp++; if (b_pc !== 12'd2730 || b_run !== 1'b1) begin n_err++; $display("FAIL b2b_second_start: got pc=%0d run=%b want pc=2730 run=1", b_pc, b_run); end
      req = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      bit quiet;
      do_reset();
      prog_sel = 2'd0; req = 1'b1;
      tick();
      tick();
      req = 1'b0;
      for (int i = 0; i < 500; i++) tick();
      n_cmp++; if (a_pc !== 12'd500) begin n_err++; $display("FAIL midrun_pc: got %0d want 500", a_pc); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++; if (a_pc !== 12'd0 || a_cnt !== 16'd0) begin n_err++; $display("FAIL midrun_reset_vals: got pc=%0d cnt=%0d want 0 0", a_pc, a_cnt); end
      n_cmp++; if ({a_run, a_done, a_to} !== 3'b000) begin n_err++; $display("FAIL midrun_reset_flags: got %b want 000", {a_run, a_done, a_to}); end
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_done !== 1'b0 || a_run !== 1'b0) quiet = 1'b0;
      end
      n_cmp++; if (!quiet) begin n_err++; $display("FAIL midrun_no_done: got done=%b run=%b want 0 0", a_done, a_run); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_jump();
      test_stall_halt();
      test_watchdog();
      test_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got no completion want finish before 1000000");
      $fatal(1, "simulation time limit");
   end

endmodule
